// File: rtl/wb_register_file_if.sv
// Bus bundle between the MEM/WB pipeline register, the ID read ports and
// the writeback stage. The master drives the writeback controls and read indices.
interface wb_register_file_if #(
  parameter int DATA_W = 32
);
  logic              MemToReg;
  logic [1:0]        RegWrite;
  logic              Jal;
  logic [4:0]        RegWriteAddress;
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] PCAdderOut;
  logic [DATA_W-1:0] MemReadData;
  logic [4:0]        ReadAddress1;
  logic [4:0]        ReadAddress2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        WriteAddress;
  logic              WriteEnable;

  // No valid/ready handshake: every cycle is a writeback slot.
  // A bubble is signalled by RegWrite[0]=0. All outputs are combinational.
  modport master (
    output MemToReg, RegWrite, Jal, RegWriteAddress,
           ALUResult, PCAdderOut, MemReadData,
           ReadAddress1, ReadAddress2,
    input  ReadData1, ReadData2, WriteData, WriteAddress, WriteEnable
  );

  modport slave (
    input  MemToReg, RegWrite, Jal, RegWriteAddress,
           ALUResult, PCAdderOut, MemReadData,
           ReadAddress1, ReadAddress2,
    output ReadData1, ReadData2, WriteData, WriteAddress, WriteEnable
  );
endinterface

// File: rtl/wb_register_file.sv
// Writeback select plus 32-entry GPR file with two combinational read ports.
// Same-cycle writes are bypassed to the read ports; $0 always reads zero.
module wb_register_file #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] SP_INIT  = '0,
  parameter int                LINK_REG = 31
) (
  input logic                 Clk,
  input logic                 Reset,
  wb_register_file_if.slave   bus
);
  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);
  localparam int         SP_IDX   = 29;

  logic [DATA_W-1:0] r_regs [32];

  logic [DATA_W-1:0] w_wdata;
  logic [4:0]        w_waddr;
  logic              w_we;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_unused_regwrite_hi;

  // Reserved enable bit is deliberately ignored.
  assign w_unused_regwrite_hi = bus.RegWrite[1];

  always_comb begin
    w_wdata = bus.MemToReg ? bus.MemReadData : bus.ALUResult;
    w_waddr = bus.RegWriteAddress;
    if (bus.Jal) begin
      w_wdata = bus.PCAdderOut;
      w_waddr = LINK_IDX;
    end
    w_we = bus.RegWrite[0] & ~Reset & (w_waddr != 5'd0);
  end

  always_comb begin
    w_rd1 = r_regs[bus.ReadAddress1];
    if (bus.ReadAddress1 == 5'd0)
      w_rd1 = '0;
    else if (w_we && (bus.ReadAddress1 == w_waddr))
      w_rd1 = w_wdata;
  end

  always_comb begin
    w_rd2 = r_regs[bus.ReadAddress2];
    if (bus.ReadAddress2 == 5'd0)
      w_rd2 = '0;
    else if (w_we && (bus.ReadAddress2 == w_waddr))
      w_rd2 = w_wdata;
  end

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++)
        r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
    end else if (w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  assign bus.WriteData    = w_wdata;
  assign bus.WriteAddress = w_waddr;
  assign bus.WriteEnable  = w_we;
  assign bus.ReadData1    = w_rd1;
  assign bus.ReadData2    = w_rd2;
endmodule

// File: tb/tb_wb_register_file.sv
// Bench for wb_register_file: directed vectors with literal expectations plus
// an every-cycle comparison against an array model of the register file.
module tb_wb_register_file;
  localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;

  logic Clk;
  logic Reset;

  wb_register_file_if #(.DATA_W(32)) bus ();

  wb_register_file #(
    .DATA_W   (32),
    .SP_INIT  (SP_VAL),
    .LINK_REG (31)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  logic [31:0] m_regs [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: what the outputs must be given the current inputs and model contents.
  function automatic logic [4:0] m_waddr();
    return bus.Jal ? 5'd31 : bus.RegWriteAddress;
  endfunction

  function automatic logic [31:0] m_wdata();
    if (bus.Jal) return bus.PCAdderOut;
    return bus.MemToReg ? bus.MemReadData : bus.ALUResult;
  endfunction

  function automatic logic m_we();
    return bus.RegWrite[0] && !Reset && (m_waddr() != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_we() && a == m_waddr()) return m_wdata();
    return m_regs[a];
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? SP_VAL : 32'd0;
    end else if (m_we()) begin
      m_regs[m_waddr()] = m_wdata();
    end
  end

  // Scoreboard compare on every cycle once the model is initialised.
  always @(negedge Clk) begin
    if (check_en) begin
      check("m_wdata", bus.WriteData, m_wdata());
      check("m_waddr", 32'(bus.WriteAddress), 32'(m_waddr()));
      check("m_we",    32'(bus.WriteEnable), 32'(m_we()));
      check("m_rd1",   bus.ReadData1, m_read(bus.ReadAddress1));
      check("m_rd2",   bus.ReadData2, m_read(bus.ReadAddress2));
    end
  end

  // Driver tasks
  task automatic drive(input logic rst, input logic [1:0] rw, input logic m2r, input logic jal,
                       input logic [4:0] addr, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] mem, input logic [4:0] ra1, input logic [4:0] ra2);
    Reset               = rst;
    bus.RegWrite        = rw;
    bus.MemToReg        = m2r;
    bus.Jal             = jal;
    bus.RegWriteAddress = addr;
    bus.ALUResult       = alu;
    bus.PCAdderOut      = pc;
    bus.MemReadData     = mem;
    bus.ReadAddress1    = ra1;
    bus.ReadAddress2    = ra2;
  endtask

  task automatic read_only(input logic [4:0] ra1, input logic [4:0] ra2);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, ra1, ra2);
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Reset with a write pending: it must not be enabled.
    drive(1'b1, 2'b01, 1'b0, 1'b0, 5'd8, 32'h1111_1111, 32'd0, 32'd0, 5'd8, 5'd29);
    @(negedge Clk);
    check("we_in_reset", 32'(bus.WriteEnable), 32'd0);
    next_cycle();
    check_en = 1'b1;

    // Every index reads its reset value.
    for (int i = 0; i < 16; i++) begin
      read_only(5'(i), 5'(i + 16));
      @(negedge Clk);
      check("reset_rd1", bus.ReadData1, 32'd0);
      check("reset_rd2", bus.ReadData2, (i + 16 == 29) ? SP_VAL : 32'd0);
      next_cycle();
    end

    // ALU writeback with bypass, then persistence.
    drive(1'b0, 2'b01, 1'b0, 1'b0, 5'd8, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_0000, 5'd8, 5'd9);
    @(negedge Clk);
    check("bypass_rd1", bus.ReadData1, 32'hDEAD_BEEF);
    check("bypass_rd2_other", bus.ReadData2, 32'd0);
    next_cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 5'd3, 32'd0, 32'd0, 32'd0, 5'd8, 5'd3);
    @(negedge Clk);
    check("held_reg8", bus.ReadData1, 32'hDEAD_BEEF);
    next_cycle();

    // Load writeback selects memory data.
    drive(1'b0, 2'b01, 1'b1, 1'b0, 5'd9, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678, 5'd1, 5'd9);
    @(negedge Clk);
    check("mem_wdata", bus.WriteData, 32'h1234_5678);
    check("mem_bypass_rd2", bus.ReadData2, 32'h1234_5678);
    next_cycle();
    read_only(5'd9, 5'd8);
    @(negedge Clk);
    check("reg9", bus.ReadData1, 32'h1234_5678);
    next_cycle();

    // Jal redirects to $31.
    drive(1'b0, 2'b01, 1'b0, 1'b1, 5'd5, 32'h0000_0111, 32'h0000_0040, 32'd0, 5'd31, 5'd5);
    @(negedge Clk);
    check("jal_waddr", 32'(bus.WriteAddress), 32'd31);
    check("jal_wdata", bus.WriteData, 32'h0000_0040);
    check("jal_bypass31", bus.ReadData1, 32'h0000_0040);
    check("jal_reg5_nobypass", bus.ReadData2, 32'd0);
    next_cycle();
    read_only(5'd31, 5'd5);
    @(negedge Clk);
    check("reg31", bus.ReadData1, 32'h0000_0040);
    check("reg5_unchanged", bus.ReadData2, 32'd0);
    next_cycle();

    // Jal with destination 0 still writes $31.
    drive(1'b0, 2'b01, 1'b0, 1'b1, 5'd0, 32'd0, 32'h0000_0080, 32'd0, 5'd0, 5'd31);
    @(negedge Clk);
    check("jal0_we", 32'(bus.WriteEnable), 32'd1);
    next_cycle();
    read_only(5'd31, 5'd0);
    @(negedge Clk);
    check("reg31_jal0", bus.ReadData1, 32'h0000_0080);
    next_cycle();

    // Write to $0 is ignored.
    drive(1'b0, 2'b01, 1'b0, 1'b0, 5'd0, 32'hAAAA_AAAA, 32'd0, 32'd0, 5'd0, 5'd0);
    @(negedge Clk);
    check("r0_we", 32'(bus.WriteEnable), 32'd0);
    check("r0_rd1", bus.ReadData1, 32'd0);
    check("r0_rd2", bus.ReadData2, 32'd0);
    next_cycle();
    read_only(5'd0, 5'd0);
    @(negedge Clk);
    check("r0_after", bus.ReadData1, 32'd0);
    next_cycle();

    // Both ports on the bypassed index; RegWrite=11 behaves as 01.
    drive(1'b0, 2'b11, 1'b0, 1'b0, 5'd12, 32'hCAFE_0001, 32'd0, 32'd0, 5'd12, 5'd12);
    @(negedge Clk);
    check("same_rd1", bus.ReadData1, 32'hCAFE_0001);
    check("same_rd2", bus.ReadData2, 32'hCAFE_0001);
    next_cycle();

    // Overwrite $sp.
    drive(1'b0, 2'b01, 1'b0, 1'b0, 5'd29, 32'h0000_8000, 32'd0, 32'd0, 5'd12, 5'd29);
    @(negedge Clk);
    check("reg12", bus.ReadData1, 32'hCAFE_0001);
    next_cycle();

    // Reset with a pending write: no bypass, old contents visible, then cleared.
    drive(1'b0, 2'b01, 1'b0, 1'b0, 5'd10, 32'd3, 32'd0, 32'd0, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 2'b01, 1'b0, 1'b0, 5'd10, 32'd7, 32'd0, 32'd0, 5'd10, 5'd29);
    @(negedge Clk);
    check("rst_nobypass", bus.ReadData1, 32'd3);
    check("rst_sp_old", bus.ReadData2, 32'h0000_8000);
    check("rst_we", 32'(bus.WriteEnable), 32'd0);
    next_cycle();
    read_only(5'd10, 5'd29);
    @(negedge Clk);
    check("reg10_reset", bus.ReadData1, 32'd0);
    check("sp_reset", bus.ReadData2, SP_VAL);
    next_cycle();
    read_only(5'd8, 5'd31);
    @(negedge Clk);
    check("reg8_reset", bus.ReadData1, 32'd0);
    check("reg31_reset", bus.ReadData2, 32'd0);
    next_cycle();

    // Reserved enable bit alone does nothing.
    drive(1'b0, 2'b10, 1'b0, 1'b0, 5'd11, 32'h0000_0055, 32'd0, 32'd0, 5'd11, 5'd11);
    @(negedge Clk);
    check("rw10_we", 32'(bus.WriteEnable), 32'd0);
    check("rw10_rd1", bus.ReadData1, 32'd0);
    next_cycle();
    read_only(5'd11, 5'd0);
    @(negedge Clk);
    check("reg11_unwritten", bus.ReadData1, 32'd0);
    next_cycle();

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
